down_count_sequencer: RTL and testbench
=======================================

DOWN_COUNT_SEQUENCER -- requirements
Module: down_count_sequencer

Interface
REQ-001 Parameter CNT_W, default 4, width of the down-count value.
REQ-002 Parameter DIV_W, default 4, width of the prescale divisor.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 ClrN  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a count run; accepted only while ready=1.
REQ-006 load_val  input  CNT_W  initial count value, captured when start is accepted.
REQ-007 div  input  DIV_W  prescale setting, captured when start is accepted; one decrement per div+1 un-paused RUN cycles.
REQ-008 auto_reload  input  1  captured when start is accepted; 1 = reload and continue at terminal count.
REQ-009 pause  input  1  level; freezes prescaler and count while high.
REQ-010 abort  input  1  synchronous cancel of any run.
REQ-011 count  output  CNT_W  current count value.
REQ-012 ready  output  1  high in IDLE or EXPIRED.
REQ-013 busy  output  1  high in RUN or HOLD.
REQ-014 done  output  1  one-cycle pulse per terminal count.
REQ-015 expired  output  1  level; high in EXPIRED only.
REQ-016 wraps  output  4  number of terminal counts since last accepted start; saturates at 15.

Function
REQ-017 The block SHALL implement exactly four states: IDLE, RUN, HOLD, EXPIRED.
REQ-018 IDLE/EXPIRED with start=1, abort=0 -> RUN next cycle; count=load_val, prescaler=0, wraps=0, reload value/div/auto_reload latched.
REQ-019 start SHALL be ignored while busy=1; latched values SHALL NOT change mid-run.
REQ-020 RUN with pause=1 -> HOLD; HOLD with pause=0 -> RUN; in HOLD, count and prescaler SHALL be held.
REQ-021 In RUN with pause=0, a tick occurs when prescaler==latched div; on a tick the prescaler clears, otherwise it increments.
REQ-022 On a tick with count!=0, count SHALL decrement by 1; no other count change occurs in RUN.
REQ-023 On a tick with count==0 (terminal): done=1 next cycle; wraps increments unless already 15.
REQ-024 Terminal with auto_reload latched 1: count reloads the latched load value, prescaler=0, state stays RUN.
REQ-025 Terminal with auto_reload latched 0: state -> EXPIRED, count stays 0.
REQ-026 Latency: with load value L and div D, first done SHALL be high exactly (L+1)*(D+1)+1 cycles after the cycle in which start was sampled; subsequent reload periods are (L+1)*(D+1) cycles.
REQ-027 load_val=0 SHALL be legal: terminal on the first tick.
REQ-028 abort=1 in any state SHALL force IDLE next cycle, count=0, prescaler=0, no done; abort has priority over start, pause and a coincident tick.
REQ-029 pause and a coincident tick: pause wins; no decrement that cycle.
REQ-030 done SHALL never be high for two consecutive cycles unless D=0, L=0, auto_reload=1.

Reset
REQ-031 ClrN low SHALL immediately force IDLE, count=0, prescaler=0, wraps=0, done=0, latched values=0, regardless of Clk.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse; first start is accepted on the first rising edge after ClrN deasserts.
REQ-033 After reset: ready=1, busy=0, expired=0.

Structure
REQ-034 A shared package down_count_pkg SHALL hold the state enumeration and CNT_W/DIV_W default constants.
REQ-035 The prescaler SHALL be a sub-module tick_prescaler (inputs: enable, clear, div; output: tick); all other logic resides in the top module.
REQ-036 All outputs SHALL be registered or decoded solely from the state register.

Verification
REQ-037 Reset, start with L=3, D=0, auto_reload=0 -> count 3,2,1,0; done high on cycle 5 after start; expired=1, ready=1.
REQ-038 L=3, D=2, auto_reload=1 -> done on cycle 13, then every 12 cycles; wraps=1,2,3; saturates at 15.
REQ-039 L=2, D=0, pause high 4 cycles mid-run -> count frozen, HOLD, done delayed by exactly 4 cycles.
REQ-040 abort asserted with start on the same cycle, and abort on a terminal tick -> IDLE, count=0, no done.
REQ-041 ClrN pulsed low between edges mid-run -> outputs reset immediately; start while busy ignored; L=0, D=0 -> done on cycle 2.

Source files
------------

// File: rtl/down_count_pkg.sv
// down_count_pkg
// Shared definitions for the down-count sequencer: the sequencer state
// enumeration, default widths for count and prescale divisor, and the
// saturation limit of the terminal-count (wrap) counter.
package down_count_pkg;

    localparam int unsigned CNT_W_DEFAULT = 4;
    localparam int unsigned DIV_W_DEFAULT = 4;

    localparam logic [3:0] WRAP_MAX = 4'd15;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StHold    = 2'd2,
        StExpired = 2'd3
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Divides enabled cycles by (div + 1): tick is high on every enabled cycle
// in which the internal count equals div, after which the count restarts.
// Ports:
//   Clk     - clock, rising edge
//   ClrN    - asynchronous active-low reset
//   enable  - advance the prescaler this cycle
//   clear   - synchronous restart to zero (wins over enable)
//   div     - divisor setting; one tick per div+1 enabled cycles
//   tick    - combinational tick strobe (only meaningful while enable=1)
module tick_prescaler #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pre_q;

    assign tick = enable && (pre_q == div);

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            pre_q <= '0;
        end else if (clear) begin
            pre_q <= '0;
        end else if (enable) begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end

endmodule

// File: rtl/down_count_sequencer.sv
// down_count_sequencer
// Programmable down-counter with prescaler, pause, abort and optional
// auto-reload. A run is started from IDLE or EXPIRED; the count decrements
// once per div+1 un-paused busy cycles and a terminal tick occurs when a
// tick arrives with the count already at zero.
// Ports:
//   Clk, ClrN    - clock and asynchronous active-low reset
//   start        - begin a run (accepted only while ready)
//   load_val     - initial / reload count, latched on accepted start
//   div          - prescale setting, latched on accepted start
//   auto_reload  - reload and continue at terminal count, latched on start
//   pause        - level; freezes prescaler and count
//   abort        - synchronous cancel, highest priority
//   count        - current count value
//   ready/busy   - IDLE or EXPIRED / RUN or HOLD
//   done         - one-cycle pulse per terminal count
//   expired      - high in EXPIRED
//   wraps        - terminal counts since last accepted start, saturating
module down_count_sequencer
    import down_count_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic [DIV_W-1:0] div,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [CNT_W-1:0] count,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output logic [3:0]       wraps
);

    state_t           state_q;
    logic [CNT_W-1:0] load_q;
    logic [DIV_W-1:0] div_q;
    logic             reload_q;

    logic             accept;
    logic             run_en;
    logic             tick;

    // Outputs decoded solely from the state register.
    always_comb begin
        ready   = (state_q == StIdle) || (state_q == StExpired);
        busy    = (state_q == StRun) || (state_q == StHold);
        expired = (state_q == StExpired);
    end

    assign accept = ready && start && !abort;
    // HOLD with pause released counts as an active cycle so a pause of N
    // cycles delays the run by exactly N cycles.
    assign run_en = busy && !pause && !abort;

    tick_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .Clk    (Clk),
        .ClrN   (ClrN),
        .enable (run_en),
        .clear  (accept || abort),
        .div    (div_q),
        .tick   (tick)
    );

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_q  <= StIdle;
            count    <= '0;
            wraps    <= '0;
            done     <= 1'b0;
            load_q   <= '0;
            div_q    <= '0;
            reload_q <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                count   <= '0;
            end else begin
                case (state_q)
                    StIdle, StExpired: begin
                        if (start) begin
                            state_q  <= StRun;
                            count    <= load_val;
                            wraps    <= '0;
                            load_q   <= load_val;
                            div_q    <= div;
                            reload_q <= auto_reload;
                        end
                    end
                    StRun, StHold: begin
                        if (pause) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StRun;
                            if (tick) begin
                                if (count != '0) begin
                                    count <= count - 1'b1;
                                end else begin
                                    done <= 1'b1;
                                    if (wraps != WRAP_MAX) begin
                                        wraps <= wraps + 4'd1;
                                    end
                                    if (reload_q) begin
                                        count <= load_q;
                                    end else begin
                                        state_q <= StExpired;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        count   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_count_sequencer.sv
// tb_down_count_sequencer
// Directed scenarios followed by random stimulus, every cycle compared
// against an arithmetic reference model: progress is tracked as the number
// of active (busy, un-paused) cycles since start, and count, done and wraps
// are derived from it by division and modulo.
module tb_down_count_sequencer;

    localparam int CW = 4;
    localparam int DW = 4;

    logic          Clk = 1'b0;
    logic          ClrN = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic [DW-1:0] div = '0;
    logic          auto_reload = 1'b0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;

    logic [CW-1:0] count;
    logic          ready;
    logic          busy;
    logic          done;
    logic          expired;
    logic [3:0]    wraps;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 = idle, 1 = busy, 2 = expired.
    int m_mode, m_l, m_d, m_n, m_count, m_wraps, m_done;
    bit m_ar;

    int cyc;
    int done_at[$];

    always #5 Clk = ~Clk;

    down_count_sequencer #(
        .CNT_W (CW),
        .DIV_W (DW)
    ) dut (
        .Clk         (Clk),
        .ClrN        (ClrN),
        .start       (start),
        .load_val    (load_val),
        .div         (div),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .expired     (expired),
        .wraps       (wraps)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_l = 0; m_d = 0; m_n = 0;
        m_count = 0; m_wraps = 0; m_done = 0; m_ar = 1'b0;
    endtask

    // Apply one rising edge to the model using the currently driven inputs.
    task automatic model_edge();
        int k;
        m_done = 0;
        if (abort) begin
            m_mode = 0;
            m_count = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_l = int'(load_val); m_d = int'(div); m_ar = auto_reload;
                m_n = 0; m_count = m_l; m_wraps = 0;
            end
        end else if (!pause) begin
            m_n++;
            k = m_n / (m_d + 1);
            if ((m_n % (m_d + 1)) == 0 && (k % (m_l + 1)) == 0) begin
                m_done = 1;
                m_wraps = (k / (m_l + 1) > 15) ? 15 : k / (m_l + 1);
                if (!m_ar) m_mode = 2;
            end
            m_count = (m_mode == 2) ? 0 : m_l - (k % (m_l + 1));
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".wraps"}, 32'(wraps), 32'(m_wraps));
        chk({tag, ".ready"}, 32'(ready), 32'(m_mode != 1));
        chk({tag, ".busy"}, 32'(busy), 32'(m_mode == 1));
        chk({tag, ".expired"}, 32'(expired), 32'(m_mode == 2));
    endtask

    task automatic cycle(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        cyc++;
        if (done) done_at.push_back(cyc);
        check_all($sformatf("%s@%0d", tag, cyc));
    endtask

    task automatic begin_run();
        cyc = 0;
        done_at.delete();
    endtask

    function automatic int done_idx(input int i);
        return (done_at.size() > i) ? done_at[i] : -1;
    endfunction

    // One cycle with start presented; this is cycle 1 of the run.
    task automatic go(input int lv, input int dv, input bit ar);
        start = 1'b1;
        load_val = CW'(lv);
        div = DW'(dv);
        auto_reload = ar;
        cycle("start");
        start = 1'b0;
    endtask

    initial begin
        // Reset state, checked between edges while ClrN is low.
        model_reset();
        #2;
        check_all("reset");
        @(posedge Clk);
        #3;
        ClrN = 1'b1;

        // L=3, D=0, no reload: 3,2,1,0 then done on cycle 5 and EXPIRED.
        begin_run();
        go(3, 0, 1'b0);
        repeat (7) cycle("s037");
        chk("s037_first_done", 32'(done_idx(0)), 32'd5);
        chk("s037_done_count", 32'(done_at.size()), 32'd1);
        chk("s037_expired", 32'(expired), 32'd1);

        // L=3, D=2, reload: done on 13 then every 12; wraps saturates at 15.
        begin_run();
        go(3, 2, 1'b1);
        repeat (13 + 12 * 16) cycle("s038");
        chk("s038_done0", 32'(done_idx(0)), 32'd13);
        chk("s038_done1", 32'(done_idx(1)), 32'd25);
        chk("s038_done2", 32'(done_idx(2)), 32'd37);
        chk("s038_wraps_sat", 32'(wraps), 32'd15);
        abort = 1'b1;
        cycle("s038_abort");
        abort = 1'b0;

        // L=2, D=0 with pause held for 4 cycles: done moves from 4 to 8.
        begin_run();
        go(2, 0, 1'b0);
        cycle("s039");
        pause = 1'b1;
        repeat (4) cycle("s039_pause");
        pause = 1'b0;
        repeat (5) cycle("s039");
        chk("s039_done_delay", 32'(done_idx(0)), 32'd8);

        // Abort together with start: stays idle.
        begin_run();
        start = 1'b1; abort = 1'b1; load_val = CW'(7);
        cycle("s040_abort_start");
        start = 1'b0; abort = 1'b0;
        chk("s040_not_busy", 32'(busy), 32'd0);
        // Abort on the terminal tick of L=1, D=1 (terminal at cycle 5).
        begin_run();
        go(1, 1, 1'b1);
        repeat (3) cycle("s040");
        abort = 1'b1;
        cycle("s040_abort_term");
        abort = 1'b0;
        repeat (2) cycle("s040_after");
        chk("s040_no_done", 32'(done_at.size()), 32'd0);
        chk("s040_count0", 32'(count), 32'd0);

        // Asynchronous reset between edges mid-run.
        begin_run();
        go(5, 1, 1'b0);
        repeat (3) cycle("s041_run");
        #3;
        ClrN = 1'b0;
        #1;
        model_reset();
        check_all("s041_async");
        @(posedge Clk);
        #1;
        check_all("s041_held");
        #2;
        ClrN = 1'b1;
        // First edge after release accepts start; a second start is ignored.
        begin_run();
        go(4, 0, 1'b0);
        cycle("s041");
        start = 1'b1; load_val = CW'(1); div = DW'(3);
        cycle("s041_ignored");
        start = 1'b0;
        repeat (5) cycle("s041");
        chk("s041_busy_start_ignored", 32'(done_idx(0)), 32'd6);
        // L=0, D=0: done on cycle 2.
        begin_run();
        go(0, 0, 1'b0);
        repeat (2) cycle("s041_l0");
        chk("s041_l0_done", 32'(done_idx(0)), 32'd2);
        // L=0, D=0 with reload: done every cycle.
        begin_run();
        go(0, 0, 1'b1);
        repeat (4) cycle("s041_l0r");
        chk("s041_l0r_dones", 32'(done_at.size()), 32'd4);
        abort = 1'b1;
        cycle("s041_abort");
        abort = 1'b0;

        // Random stimulus against the model.
        begin_run();
        repeat (600) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            pause = ($urandom_range(0, 5) == 0);
            load_val = CW'($urandom_range(0, 5));
            div = DW'($urandom_range(0, 2));
            auto_reload = ($urandom_range(0, 1) == 1);
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
